// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and access-legality helper for the load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  // Size/alignment check; unsigned variants exist only for loads.
  function automatic logic access_legal(input logic is_store, input logic [2:0] f3,
                                        input logic [1:0] a);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~a[0];
      F3_W:    ok = (a == 2'b00);
      F3_BU:   ok = ~is_store;
      F3_HU:   ok = ~is_store & ~a[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/halfword of a read word and sign- or zero-extends it.
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane select and extension
  always_comb begin
    byte_s = 8'd0;
    half_s = 16'd0;
    result = 32'd0;
    case (addr_lo)
      2'd0:    byte_s = rdata[7:0];
      2'd1:    byte_s = rdata[15:8];
      2'd2:    byte_s = rdata[23:16];
      2'd3:    byte_s = rdata[31:24];
      default: byte_s = 8'd0;
    endcase
    if (addr_lo[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
    case (funct3)
      F3_B:    result = {{24{byte_s[7]}}, byte_s};
      F3_BU:   result = {24'd0, byte_s};
      F3_H:    result = {{16{half_s[15]}}, half_s};
      F3_HU:   result = {16'd0, half_s};
      F3_W:    result = rdata;
      default: result = 32'd0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: one valid/ready bus transaction per memory instruction,
// stalling the core until the access retires or faults.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic        Stall,
  output logic [31:0] ReadData,
  output logic        LoadValid,
  output logic        Fault,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  output logic [3:0]  MemBE,
  input  logic        MemReady,
  input  logic [31:0] MemRData
);

  lsu_state_e  state_r, next_s;
  logic        access_s, legal_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_s, aligned_s;

  logic        mem_req_r, mem_we_r, load_done_r, fault_r;
  logic [31:0] mem_addr_r, mem_wdata_r, read_data_r;
  logic [3:0]  mem_be_r;
  logic [1:0]  a_lo_r;
  logic [2:0]  f3_r;

  assign access_s = MemRead | MemWrite;
  assign legal_s  = access_legal(MemWrite, Funct3, ALUResult[1:0]);

  // Store-lane formatting; loads always read the full word
  always_comb begin
    be_s    = BE_WORD;
    wdata_s = 32'd0;
    if (MemWrite) begin
      case (Funct3)
        F3_B: begin
          be_s    = BE_BYTE << ALUResult[1:0];
          wdata_s = {4{WriteData[7:0]}};
        end
        F3_H: begin
          be_s    = BE_HALF << {ALUResult[1], 1'b0};
          wdata_s = {2{WriteData[15:0]}};
        end
        F3_W: begin
          be_s    = BE_WORD;
          wdata_s = WriteData;
        end
        default: begin
          be_s    = BE_WORD;
          wdata_s = 32'd0;
        end
      endcase
    end else begin
      be_s    = BE_WORD;
      wdata_s = 32'd0;
    end
  end

  load_align u_align (
    .rdata   (MemRData),
    .addr_lo (a_lo_r),
    .funct3  (f3_r),
    .result  (aligned_s)
  );

  // Next-state logic
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (access_s) begin
          next_s = legal_s ? REQ : DONE;
        end else begin
          next_s = IDLE;
        end
      end
      REQ: begin
        if (MemReady) begin
          next_s = DONE;
        end else begin
          next_s = REQ;
        end
      end
      DONE:    next_s = IDLE;
      default: next_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Request capture, load-data latch and completion flags (flags live exactly in DONE)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 32'd0;
      mem_wdata_r <= 32'd0;
      mem_be_r    <= 4'd0;
      a_lo_r      <= 2'd0;
      f3_r        <= 3'd0;
      read_data_r <= 32'd0;
      load_done_r <= 1'b0;
      fault_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (access_s && legal_s) begin
            mem_req_r   <= 1'b1;
            mem_we_r    <= MemWrite;
            mem_addr_r  <= {ALUResult[31:2], 2'b00};
            mem_wdata_r <= wdata_s;
            mem_be_r    <= be_s;
            a_lo_r      <= ALUResult[1:0];
            f3_r        <= Funct3;
          end else if (access_s) begin
            fault_r <= 1'b1;
          end
        end
        REQ: begin
          if (MemReady) begin
            mem_req_r <= 1'b0;
            if (!mem_we_r) begin
              read_data_r <= aligned_s;
              load_done_r <= 1'b1;
            end
          end
        end
        DONE: begin
          load_done_r <= 1'b0;
          fault_r     <= 1'b0;
        end
        default: begin
          mem_req_r   <= 1'b0;
          load_done_r <= 1'b0;
          fault_r     <= 1'b0;
        end
      endcase
    end
  end

  // Gated by reset_n so a mid-transaction reset releases the core immediately
  assign Stall     = reset_n & (((state_r == IDLE) & access_s) | (state_r == REQ));
  assign ReadData  = read_data_r;
  assign LoadValid = load_done_r;
  assign Fault     = fault_r;
  assign MemReq    = mem_req_r;
  assign MemWe     = mem_we_r;
  assign MemAddr   = mem_addr_r;
  assign MemWData  = mem_wdata_r;
  assign MemBE     = mem_be_r;

endmodule
